// File: rtl/anubis_inv_pi_deser.sv
// Byte-serial receiver that scatters Pi-domain bytes into inverse-Pi order across ping-pong buffers.
// Optional ANUBIS_INV_PI_SELFCHECK_EN adds a shadow arrival-order register and a forward-Pi compare.
module anubis_inv_pi_deser (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    input  logic         sync,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         frame_err,
    output logic         chk_err
);
    logic [127:0] buf_q [2];
    logic [127:0] buf_d [2];
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   wpos_q, wpos_d;
    logic         fp_q, fp_d;
    logic         dp_q, dp_d;
    logic [1:0]   occ_q, occ_d;
    logic         frame_err_q, frame_err_d;
    logic         accept, drain, complete;
    logic [6:0]   wbit;

    assign in_ready  = ~occ_q[1];
    assign out_valid = |occ_q;
    assign out_data  = buf_q[dp_q];
    assign frame_err = frame_err_q;

    assign accept = in_valid && in_ready && !sync;
    assign drain  = out_valid && out_ready;
    // Byte position p sits at bits [127-8p -: 8]; 15-p is the bitwise complement for 4 bits.
    assign wbit   = {~wpos_q, 3'b000};

    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        wpos_d      = wpos_q;
        fp_d        = fp_q;
        dp_d        = dp_q;
        frame_err_d = frame_err_q;
        complete    = 1'b0;
        if (sync) begin
            cnt_d  = '0;
            wpos_d = '0;
        end else if (accept) begin
            buf_d[fp_q][wbit +: 8] = in_byte;
            if (in_last != (cnt_q == 4'd15)) frame_err_d = 1'b1;
            if (cnt_q == 4'd15) begin
                cnt_d    = '0;
                wpos_d   = '0;
                fp_d     = ~fp_q;
                complete = 1'b1;
            end else begin
                cnt_d  = cnt_q + 4'd1;
                wpos_d = wpos_q + 4'd13;
            end
        end
        if (drain) dp_d = ~dp_q;
        unique case ({complete, drain})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            cnt_q       <= '0;
            wpos_q      <= '0;
            fp_q        <= 1'b0;
            dp_q        <= 1'b0;
            occ_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
            cnt_q       <= cnt_d;
            wpos_q      <= wpos_d;
            fp_q        <= fp_d;
            dp_q        <= dp_d;
            occ_q       <= occ_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef ANUBIS_INV_PI_SELFCHECK_EN
    logic [127:0] sh_q, sh_d;
    logic [127:0] fwd;
    logic         done_q;
    logic         chk_err_q, chk_err_d;
    logic [6:0]   sbit;

    assign chk_err = chk_err_q;
    assign sbit    = {~cnt_q, 3'b000};

    // One cycle after completion the finished block sits in buf_q[~fp_q] and sh_q is still intact.
    always_comb begin
        sh_d = sh_q;
        if (accept) sh_d[sbit +: 8] = in_byte;
        fwd = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            fwd[8*(15-k) +: 8] = buf_q[~fp_q][8*(15-((13*k)%16)) +: 8];
        end
        chk_err_d = chk_err_q | (done_q && (fwd != sh_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q      <= '0;
            done_q    <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            done_q    <= complete;
            chk_err_q <= chk_err_d;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_anubis_inv_pi_deser.sv
// Directed bench for anubis_inv_pi_deser: output scoreboard from an independent inverse-Pi model.
module tb_anubis_inv_pi_deser;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         sync;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         frame_err;
    logic         chk_err;

    int unsigned  tests = 0;
    int unsigned  fails = 0;
    int unsigned  cyc   = 0;
    bit           rnd   = 0;
    logic [127:0] exp_q [$];

    anubis_inv_pi_deser dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .sync      (sync),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] inv_pi(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 16; k++) y[127-8*k -: 8] = x[127-8*((5*k)%16) -: 8];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score any output handshake, check hold while stalled, advance.
    task automatic tick();
        bit           stalled;
        logic [127:0] held;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_block", out_data, 128'hx);
            else chk("block_data", out_data, exp_q.pop_front());
        end
        stalled = out_valid && !out_ready && !rst;
        held    = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (stalled && !rst) chk("hold_stable", out_data, held);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic put(input logic [7:0] b, input bit last);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input int last_at);
        for (int j = 0; j < 16; j++) put(blk[127-8*j -: 8], j == last_at);
        exp_q.push_back(inv_pi(blk));
    endtask

    task automatic drain();
        int unsigned n = 0;
        rnd       = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        chk("drain_idle", 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] blk_a, blk_b, blk_c, blk_d, seq;
        int unsigned  c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = '0;
        in_last   = 1'b0;
        sync      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_frame_err", 128'(frame_err), 128'd0);
        chk("rst_chk_err", 128'(chk_err), 128'd0);

        // Counting pattern 0x00..0x0F
        seq = 128'h000102030405060708090A0B0C0D0E0F;
        out_ready = 1'b1;
        send_block(seq, 15);
        chk("t1_valid", 128'(out_valid), 128'd1);
        chk("t1_data", out_data, 128'h00050A0F04090E03080D02070C01060B);
        tick();
        chk("t1_one_pulse", 128'(out_valid), 128'd0);
        chk("t1_frame_err", 128'(frame_err), 128'd0);
        tick();
        chk("t1_chk_err", 128'(chk_err), 128'd0);

        // Fill both buffers with the output stalled
        blk_a = 128'h112233445566778899AABBCCDDEEFF00;
        blk_b = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        blk_c = 128'hDEADBEEFCAFEBABE0123456789ABCDEF;
        blk_d = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        out_ready = 1'b0;
        send_block(blk_a, 15);
        send_block(blk_b, 15);
        chk("t2_full_in_ready", 128'(in_ready), 128'd0);
        tick();
        tick();
        chk("t2_still_full", 128'(in_ready), 128'd0);
        chk("t2_head_data", out_data, inv_pi(blk_a));
        out_ready = 1'b1;
        tick();
        chk("t2_in_ready_rise", 128'(in_ready), 128'd1);
        chk("t2_second_data", out_data, inv_pi(blk_b));
        tick();
        c0 = cyc;
        send_block(blk_c, 15);
        send_block(blk_d, 15);
        chk("t2_throughput_cycles", 128'(cyc - c0), 128'd32);
        drain();

        // Random output backpressure over 8 blocks
        rnd = 1;
        for (int b = 0; b < 8; b++) begin
            seq = {$urandom, $urandom, $urandom, $urandom};
            send_block(seq, 15);
        end
        drain();

        // sync after 7 bytes drops the partial block and the sync-cycle beat
        for (int j = 0; j < 7; j++) put(8'hA0 + 8'(j), 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        sync     = 1'b1;
        tick();
        sync     = 1'b0;
        in_valid = 1'b0;
        chk("t4_no_output", 128'(out_valid), 128'd0);
        send_block(128'h0123456789ABCDEFFEDCBA9876543210, 15);
        drain();
        chk("t4_frame_err", 128'(frame_err), 128'd0);

        // Early in_last: sticky framing error, block still completes on count
        send_block(128'h55AA55AA00FF00FF123456789ABCDEF0, 9);
        chk("t5_frame_err_set", 128'(frame_err), 128'd1);
        drain();
        chk("t5_frame_err_sticky", 128'(frame_err), 128'd1);

        // Reset with both buffers full and a partial block pending
        out_ready = 1'b0;
        send_block(blk_a, 15);
        send_block(blk_b, 15);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        exp_q.push_back(128'h0);
        void'(exp_q.pop_back());
        exp_q.delete();
        send_block(blk_c, 15);
        send_block(blk_d, 15);
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_byte  = 8'h77;
            tick();
        end
        in_valid = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_out_valid", 128'(out_valid), 128'd0);
        chk("t6_out_data", out_data, 128'd0);
        chk("t6_in_ready", 128'(in_ready), 128'd1);
        chk("t6_frame_err", 128'(frame_err), 128'd0);
        out_ready = 1'b1;
        send_block(128'h000102030405060708090A0B0C0D0E0F, 15);
        chk("t6_decode", out_data, 128'h00050A0F04090E03080D02070C01060B);
        drain();
        chk("t6_chk_err", 128'(chk_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
